// File: rtl/sprite_drawer.sv
// Rectangle sweep engine: latches a sprite origin and colour on a start strobe,
// then emits one registered pixel per clock in raster order, clipping off-screen pixels.
module sprite_drawer #(
  parameter int          BOX_W        = 4,
  parameter int          BOX_H        = 4,
  parameter int          SCREEN_W     = 160,
  parameter int          SCREEN_H     = 120,
  parameter logic [2:0]  ERASE_COLOUR = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       draw_frame,
  input  logic       erase,
  input  logic [7:0] pos_x,
  input  logic [6:0] pos_y,
  input  logic [2:0] colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  localparam logic [3:0] LAST_X = 4'(BOX_W - 1);
  localparam logic [3:0] LAST_Y = 4'(BOX_H - 1);
  localparam logic [8:0] SCR_W  = 9'(SCREEN_W);
  localparam logic [7:0] SCR_H  = 8'(SCREEN_H);

  state_t     state_q, state_d;
  logic [3:0] cx_q, cx_d, cy_q, cy_d;
  logic [7:0] base_x_q, base_x_d;
  logic [6:0] base_y_q, base_y_d;
  logic [2:0] col_q, col_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] vga_colour_q, vga_colour_d;
  logic       plot_q, plot_d, busy_q, busy_d, done_q, done_d;
  logic [8:0] sum_x;
  logic [7:0] sum_y;

  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    col_d    = col_q;

    // Counters always name the pixel presented in the cycle after this edge.
    case (state_q)
      IDLE: begin
        if (draw_frame) begin
          base_x_d = pos_x;
          base_y_d = pos_y;
          col_d    = erase ? ERASE_COLOUR : colour;
          cx_d     = 4'd0;
          cy_d     = 4'd0;
          state_d  = DRAW;
        end
      end
      DRAW: begin
        if (cx_q == LAST_X && cy_q == LAST_Y) begin
          state_d = DONE;
        end else if (cx_q == LAST_X) begin
          cx_d = 4'd0;
          cy_d = cy_q + 4'd1;
        end else begin
          cx_d = cx_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Sums are one bit wider than the ports so clipping sees the true coordinate.
    sum_x = {1'b0, base_x_d} + {5'b0, cx_d};
    sum_y = {1'b0, base_y_d} + {4'b0, cy_d};

    plot_d       = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    vga_x_d      = 8'd0;
    vga_y_d      = 7'd0;
    vga_colour_d = 3'd0;
    case (state_d)
      DRAW: begin
        busy_d       = 1'b1;
        vga_x_d      = sum_x[7:0];
        vga_y_d      = sum_y[6:0];
        vga_colour_d = col_d;
        plot_d       = (sum_x < SCR_W) && (sum_y < SCR_H);
      end
      DONE: begin
        busy_d       = 1'b1;
        done_d       = 1'b1;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cx_q         <= 4'd0;
      cy_q         <= 4'd0;
      base_x_q     <= 8'd0;
      base_y_q     <= 7'd0;
      col_q        <= 3'd0;
      vga_x_q      <= 8'd0;
      vga_y_q      <= 7'd0;
      vga_colour_q <= 3'd0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      base_x_q     <= base_x_d;
      base_y_q     <= base_y_d;
      col_q        <= col_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sprite_drawer.sv
// Bench for sprite_drawer: a queue-based frame model checked every cycle,
// plus directed sweeps with hand-computed pixel counts, corners and timing.
module tb_sprite_drawer;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic       draw_frame = 1'b0;
  logic       erase = 1'b0;
  logic [7:0] pos_x = 8'd0;
  logic [6:0] pos_y = 7'd0;
  logic [2:0] colour = 3'd0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot, busy, done;

  int tests = 0;
  int fails = 0;

  sprite_drawer dut (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .draw_frame(draw_frame),
    .erase     (erase),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .colour    (colour),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic       plot;
    logic       busy;
    logic       done;
    logic       draw;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_cur = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  // Model: a whole frame is queued as a list of cycles when a start is accepted.
  initial begin
    exp_t e;
    int   xs, ys;
    forever begin
      @(posedge CLOCK_50);
      if (!resetn) begin
        exp_q.delete();
        exp_cur = '0;
      end else if (exp_q.size() > 0) begin
        exp_cur = exp_q.pop_front();
      end else if (!exp_cur.busy && draw_frame) begin
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            xs     = int'(pos_x) + c;
            ys     = int'(pos_y) + r;
            e      = '0;
            e.busy = 1'b1;
            e.draw = 1'b1;
            e.plot = (xs < 160) && (ys < 120);
            e.x    = xs[7:0];
            e.y    = ys[6:0];
            e.c    = erase ? 3'b000 : colour;
            exp_q.push_back(e);
          end
        end
        e      = '0;
        e.busy = 1'b1;
        e.done = 1'b1;
        exp_q.push_back(e);
        exp_cur = exp_q.pop_front();
      end else begin
        exp_cur = '0;
      end
    end
  end

  initial begin
    @(posedge CLOCK_50);
    forever begin
      @(negedge CLOCK_50);
      chk("busy", 32'(busy), 32'(exp_cur.busy));
      chk("done", 32'(done), 32'(exp_cur.done));
      chk("plot", 32'(plot), 32'(exp_cur.plot));
      if (exp_cur.draw || !exp_cur.busy) begin
        chk("vga_x", 32'(vga_x), 32'(exp_cur.x));
        chk("vga_y", 32'(vga_y), 32'(exp_cur.y));
        chk("vga_colour", 32'(vga_colour), 32'(exp_cur.c));
      end
    end
  end

  // One sweep; k counts cycles after the accepting edge. draw_frame is raised
  // during cycles p1/p2/p3 to probe that strobes are ignored while busy.
  task automatic sweep(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc,
                       input logic pe, input int p1, input int p2, input int p3,
                       output int nplot, output int ndone, output int done_cyc,
                       output int busy_fall, output logic [7:0] fx, output logic [6:0] fy,
                       output logic [7:0] lx, output logic [6:0] ly, output logic [2:0] fc);
    @(negedge CLOCK_50);
    draw_frame = 1'b1;
    pos_x = px; pos_y = py; colour = pc; erase = pe;
    nplot = 0; ndone = 0; done_cyc = 0; busy_fall = 0;
    fx = '0; fy = '0; lx = '0; ly = '0; fc = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLOCK_50);
      if (k == 4) begin
        pos_x = 8'd99; pos_y = 7'd99; colour = ~pc; erase = ~pe;
      end
      if (plot) begin
        if (nplot == 0) begin fx = vga_x; fy = vga_y; fc = vga_colour; end
        lx = vga_x; ly = vga_y;
        nplot++;
      end
      if (done) begin
        ndone++;
        if (done_cyc == 0) done_cyc = k;
      end
      draw_frame = (k == p1) || (k == p2) || (k == p3);
      if (!busy) begin
        busy_fall = k;
        draw_frame = 1'b0;
        break;
      end
    end
    $display("[TB] sweep pos=(%0d,%0d) col=%0d erase=%0d plots=%0d done@%0d busy_low@%0d",
             px, py, pc, pe, nplot, done_cyc, busy_fall);
  endtask

  initial begin
    int nplot, ndone, done_cyc, busy_fall, d1, d2, idle_k, nd;
    logic [7:0] fx, lx;
    logic [6:0] fy, ly;
    logic [2:0] fc;

    // 1: reset held with draw_frame high, then released with no strobe
    draw_frame = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_plot", 32'(plot), 32'd0);
    draw_frame = 1'b0;
    resetn = 1'b1;
    repeat (4) @(negedge CLOCK_50);
    chk("idle_after_rst", 32'(busy), 32'd0);
    $display("[TB] reset released, idle");

    // 2: normal draw
    sweep(8'd10, 7'd20, 3'b100, 1'b0, 0, 0, 0, nplot, ndone, done_cyc, busy_fall, fx, fy, lx, ly, fc);
    chk("t2_nplot", nplot, 16);
    chk("t2_first_x", 32'(fx), 10);
    chk("t2_first_y", 32'(fy), 20);
    chk("t2_last_x", 32'(lx), 13);
    chk("t2_last_y", 32'(ly), 23);
    chk("t2_colour", 32'(fc), 32'b100);
    chk("t2_done_cyc", done_cyc, 17);
    chk("t2_ndone", ndone, 1);
    chk("t2_busy_fall", busy_fall, 18);

    // 3: erase
    sweep(8'd10, 7'd20, 3'b111, 1'b1, 0, 0, 0, nplot, ndone, done_cyc, busy_fall, fx, fy, lx, ly, fc);
    chk("t3_nplot", nplot, 16);
    chk("t3_colour", 32'(fc), 0);
    chk("t3_done_cyc", done_cyc, 17);

    // 4: bottom-right clipping
    sweep(8'd158, 7'd118, 3'b010, 1'b0, 0, 0, 0, nplot, ndone, done_cyc, busy_fall, fx, fy, lx, ly, fc);
    chk("t4_nplot", nplot, 4);
    chk("t4_first_x", 32'(fx), 158);
    chk("t4_first_y", 32'(fy), 118);
    chk("t4_last_x", 32'(lx), 159);
    chk("t4_last_y", 32'(ly), 119);
    chk("t4_done_cyc", done_cyc, 17);

    // x past 255 must not wrap back onto the screen
    sweep(8'd254, 7'd5, 3'b001, 1'b0, 0, 0, 0, nplot, ndone, done_cyc, busy_fall, fx, fy, lx, ly, fc);
    chk("wrap_nplot", nplot, 0);

    // 5: strobes while busy are dropped
    sweep(8'd40, 7'd50, 3'b011, 1'b0, 3, 16, 17, nplot, ndone, done_cyc, busy_fall, fx, fy, lx, ly, fc);
    chk("t5_nplot", nplot, 16);
    chk("t5_ndone", ndone, 1);
    chk("t5_busy_fall", busy_fall, 18);

    // 5b: strobe held high gives back-to-back sweeps
    @(negedge CLOCK_50);
    draw_frame = 1'b1;
    pos_x = 8'd20; pos_y = 7'd30; colour = 3'b101; erase = 1'b0;
    d1 = 0; d2 = 0; idle_k = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLOCK_50);
      if (done) begin
        if (d1 == 0) d1 = k;
        else if (d2 == 0) d2 = k;
      end
      if (!busy && idle_k == 0) idle_k = k;
    end
    draw_frame = 1'b0;
    chk("held_done1", d1, 17);
    chk("held_idle", idle_k, 18);
    chk("held_done2", d2, 35);
    $display("[TB] held strobe done@%0d idle@%0d done@%0d", d1, idle_k, d2);
    idle_k = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLOCK_50);
      if (!busy) begin idle_k = 1; break; end
    end
    chk("held_drain", idle_k, 1);

    // 6: reset during the 6th pixel
    @(negedge CLOCK_50);
    draw_frame = 1'b1;
    pos_x = 8'd50; pos_y = 7'd60; colour = 3'b110;
    @(negedge CLOCK_50);
    draw_frame = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    resetn = 1'b0;
    @(negedge CLOCK_50);
    chk("abort_plot", 32'(plot), 0);
    chk("abort_busy", 32'(busy), 0);
    resetn = 1'b1;
    nd = 0;
    repeat (25) begin
      @(negedge CLOCK_50);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    $display("[TB] mid-sweep reset, done pulses afterwards=%0d", nd);
    sweep(8'd30, 7'd40, 3'b001, 1'b0, 0, 0, 0, nplot, ndone, done_cyc, busy_fall, fx, fy, lx, ly, fc);
    chk("t6_first_x", 32'(fx), 30);
    chk("t6_first_y", 32'(fy), 40);
    chk("t6_nplot", nplot, 16);

    repeat (2) @(negedge CLOCK_50);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sprite_drawer.md
Name: sprite_drawer

Overview:
Draw engine directly downstream of the game state controller. On a one-cycle start strobe (the controller's draw_frame) it latches a sprite position and colour. It then sweeps a BOX_W x BOX_H rectangle pixel by pixel onto the VGA adapter's plot interface, and reports completion with a one-cycle done pulse. The same engine handles erase: the rectangle is repainted in ERASE_COLOUR, so the controller can erase, progress, redraw and stall frames.

Parameters:
BOX_W, 4, sprite width in pixels (1..16)
BOX_H, 4, sprite height in pixels (1..16)
SCREEN_W, 160, visible columns; x >= SCREEN_W is clipped
SCREEN_H, 120, visible rows; y >= SCREEN_H is clipped
ERASE_COLOUR, 3'b000, colour used when erase=1

Ports:
CLOCK_50  in  1  system clock; all logic on the rising edge
resetn  in  1  synchronous, active-low reset
draw_frame  in  1  start strobe; sampled only in IDLE
erase  in  1  sampled with draw_frame; 1 = paint ERASE_COLOUR
pos_x  in  8  top-left x; sampled with draw_frame
pos_y  in  7  top-left y; sampled with draw_frame
colour  in  3  sprite colour; sampled with draw_frame
vga_x  out  8  pixel x to the VGA adapter
vga_y  out  7  pixel y to the VGA adapter
vga_colour  out  3  pixel colour
plot  out  1  write-enable for the current vga_x/vga_y/vga_colour
busy  out  1  high in DRAW and DONE
done  out  1  one-cycle pulse after the final pixel

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-low: resetn low at a rising edge of CLOCK_50 forces IDLE. It also clears cx, cy and the latched base_x, base_y and colour registers. All outputs are 0 the cycle after.
- States:
  - IDLE: plot=0, busy=0, done=0. If draw_frame=1, latch base_x=pos_x and base_y=pos_y. Latch col = erase ? ERASE_COLOUR : colour. Clear cx and cy, then go to DRAW. Otherwise stay in IDLE.
  - DRAW: busy=1. vga_x = base_x + cx and vga_y = base_y + cy, computed in 9 and 8 bits before truncation. vga_colour = col.
    - plot=1 only if the untruncated x < SCREEN_W and y < SCREEN_H; otherwise plot=0 and the cycle is still consumed. Coordinates never wrap onto the screen.
    - Each cycle cx increments. When cx = BOX_W-1, cx returns to 0 and cy increments. This gives raster order, row-major.
    - When cx=BOX_W-1 and cy=BOX_H-1, go to DONE.
  - DONE: busy=1, done=1, plot=0 for exactly one cycle, then IDLE.
- Timing: strobe accepted at edge N. DRAW then occupies cycles N+1 .. N+BOX_W*BOX_H. done is high in cycle N+BOX_W*BOX_H+1, and busy falls one cycle later. The earliest next start is accepted in the following IDLE cycle.
- draw_frame in DRAW or DONE is ignored and not queued. A draw_frame held high re-triggers on the first IDLE cycle.
- pos_x, pos_y, colour and erase changing mid-sweep have no effect; latched values are used.
- vga_x, vga_y and vga_colour are 0 in IDLE. They hold their last values in DONE, but plot=0 there, so they are don't-care.
- Reset mid-sweep aborts immediately: no done pulse, no further plot.
- Counter widths are 4 bits each; no arithmetic overflow inside the counters for the legal parameter range.

Test Plan:
1. Reset: hold resetn=0 for 3 cycles with draw_frame=1 -> plot, busy, done, vga_x, vga_y and vga_colour all 0; the state stays IDLE after release until the next strobe.
2. Strobe with pos=(10,20), colour=3'b100, erase=0 -> 16 consecutive plot cycles. Coordinates are (10,20),(11,20),...,(13,20),(10,21),...,(13,23), all with colour 100. done is high on cycle 17 only; busy falls on cycle 18.
3. Strobe with pos=(10,20), colour=3'b111, erase=1 -> same 16 coordinates with vga_colour=000 throughout.
4. Strobe with pos=(158,118) -> 16 DRAW cycles; plot is high only for (158,118), (159,118), (158,119) and (159,119), i.e. 4 pulses. done is on cycle 17.
5. Pulse draw_frame again at DRAW cycles 3 and 16 and in the DONE cycle -> exactly 16 plots and one done. Hold draw_frame high continuously -> back-to-back sweeps separated by one DONE cycle and one IDLE cycle.
6. Assert resetn=0 during the 6th pixel -> the next cycle has plot=0 and busy=0, done never pulses, and a fresh strobe restarts at (base_x, base_y).
